// File: rtl/bsram_arb_pkg.sv
// bsram_pkg: shared widths, bridge read code and response states for the SRAM arbiter
package bsram_pkg;
   localparam int AW = 11;
   localparam int DW = 32;
   localparam int BW = 4;
   localparam int CW = 16;
   localparam logic [BW-1:0] BRD = 4'hF;
   typedef enum logic [1:0] {IDLE, RESP, HOLD} state_e;
endpackage

// File: rtl/bsram_arb_if.sv
// bsram_arb_if: bridge strobes, core valid/ready port, stall counter and macro pins
interface bsram_arb_if;
   import bsram_pkg::*;
   logic          io_bcf, bcsb, c_vld, c_rdy, c_rvl, c_rrd, st_clr, m_csb, m_web;
   logic [BW-1:0] bweb, c_we, m_wmask;
   logic [AW-1:0] badr, c_adr, m_adr;
   logic [DW-1:0] bdti, bdto, c_wdt, c_rdt, m_din, m_dout;
   logic [CW-1:0] st_cnt;
   modport slave (
      input  io_bcf, bcsb, bweb, badr, bdti, c_vld, c_we, c_adr, c_wdt, c_rrd, st_clr, m_dout,
      output bdto, c_rdy, c_rvl, c_rdt, st_cnt, m_csb, m_web, m_wmask, m_adr, m_din
   );
   modport master (
      output io_bcf, bcsb, bweb, badr, bdti, c_vld, c_we, c_adr, c_wdt, c_rrd, st_clr, m_dout,
      input  bdto, c_rdy, c_rvl, c_rdt, st_cnt, m_csb, m_web, m_wmask, m_adr, m_din
   );
endinterface

// File: rtl/bsram_arb_rsp.sv
// bsram_rsp: one-entry core read response buffer; RESP forwards live macro data, HOLD replays it
module bsram_rsp
   import bsram_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic          accept_rd_i,
   input  logic          c_rrd_i,
   input  logic [DW-1:0] m_dout_i,
   output logic          c_rvl_o,
   output logic          busy_o,
   output logic [DW-1:0] c_rdt_o
);
   state_e        state_q, state_d;
   logic [DW-1:0] hold_q, hold_d;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q <= IDLE;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
      end
   always_comb begin
      c_rvl_o = state_q != IDLE;
      busy_o  = state_q == HOLD;
      c_rdt_o = busy_o ? hold_q : m_dout_i;
      // capture before the next edge so a bridge access cannot overwrite the pending word
      hold_d  = (state_q == RESP && !c_rrd_i) ? m_dout_i : hold_q;
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = accept_rd_i ? RESP : IDLE;
         RESP:    state_d = c_rrd_i ? (accept_rd_i ? RESP : IDLE) : HOLD;
         HOLD:    state_d = c_rrd_i ? IDLE : HOLD;
         default: state_d = IDLE;
      endcase
   end
endmodule

// File: rtl/bsram_arb.sv
// bsram_arb: merges the SPI bridge strobes (always wins) and a core valid/ready port onto one SRAM macro
module bsram_arb
   import bsram_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   bsram_arb_if.slave  bus
);
   logic          bsel, acc, inc, rvl, busy;
   logic [CW-1:0] st_cnt_q, st_cnt_d;
   assign bsel       = ~bus.bcsb;
   assign bus.c_rdy  = ~rst & ~bsel & ~bus.io_bcf & ~busy & (~rvl | bus.c_rrd);
   assign acc        = bus.c_vld & bus.c_rdy;
   assign bus.m_csb  = bus.bcsb & ~acc;
   assign bus.m_web  = bsel ? bus.bweb == BRD : ~|bus.c_we;
   assign bus.m_wmask = bsel ? ~bus.bweb : bus.c_we;
   assign bus.m_adr  = bsel ? bus.badr : bus.c_adr;
   assign bus.m_din  = bsel ? bus.bdti : bus.c_wdt;
   assign bus.bdto   = bus.m_dout;
   assign bus.c_rvl  = rvl;
   assign bus.st_cnt = st_cnt_q;
   bsram_rsp u_rsp (
      .clk         (clk),
      .rst         (rst),
      .accept_rd_i (acc & ~|bus.c_we),
      .c_rrd_i     (bus.c_rrd),
      .m_dout_i    (bus.m_dout),
      .c_rvl_o     (rvl),
      .busy_o      (busy),
      .c_rdt_o     (bus.c_rdt)
   );
   // only bridge-caused stalls count; a parked HOLD response is the core's own back-pressure
   assign inc = bus.c_vld & ~bus.c_rdy & bsel & ~bus.io_bcf & ~busy;
   always_comb st_cnt_d = bus.st_clr ? '0 : (inc && !(&st_cnt_q)) ? st_cnt_q + CW'(1) : st_cnt_q;
   always_ff @(posedge clk or posedge rst)
      if (rst) st_cnt_q <= '0;
      else     st_cnt_q <= st_cnt_d;
endmodule

// File: tb/tb_bsram_arb.sv
// tb_bsram_arb: directed + random stimulus, scoreboard of expected core/bridge read data from a memory model
module tb_bsram_arb;
   import bsram_pkg::*;
   logic clk = 0;
   logic rst = 1;
   int   n_tst = 0;
   int   n_err = 0;
   bsram_arb_if bus();
   bsram_arb u_dut (.clk(clk), .rst(rst), .bus(bus.slave));
   always #5 clk = ~clk;

   logic [DW-1:0] macro   [2**AW];
   logic [DW-1:0] ref_mem [2**AW];
   always @(posedge clk)
      if (!bus.m_csb) begin
         if (!bus.m_web) begin
            for (int i = 0; i < BW; i++) if (bus.m_wmask[i]) macro[bus.m_adr][8*i +: 8] <= bus.m_din[8*i +: 8];
         end else bus.m_dout <= macro[bus.m_adr];
      end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tst++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [BW-1:0] m, input logic [DW-1:0] d);
      for (int i = 0; i < BW; i++) if (m[i]) ref_mem[a][8*i +: 8] = d[8*i +: 8];
   endtask

   // scoreboard: pending core read words, in order of acceptance
   logic [DW-1:0] q[$];
   logic          waited = 0;
   logic          bpend = 0;
   logic [DW-1:0] bexp = '0;
   logic [CW-1:0] exp_cnt = '0;
   always @(negedge clk) begin
      if (rst) begin
         q.delete();
         waited = 0;
         bpend = 0;
         exp_cnt = '0;
         chk("rst_rvl", bus.c_rvl, 0);
         chk("rst_rdy", bus.c_rdy, 0);
         chk("rst_cnt", bus.st_cnt, 0);
      end else begin
         chk("st_cnt", bus.st_cnt, exp_cnt);
         if (bpend) chk("bdto", bus.bdto, bexp);
         chk("c_rvl", bus.c_rvl, q.size() != 0);
         chk("c_rdy", bus.c_rdy, bus.bcsb & ~bus.io_bcf & (q.size() == 0 || (bus.c_rrd && !waited)));
         if (q.size() != 0) chk("c_rdt", bus.c_rdt, q[0]);
         if (!bus.bcsb)
            chk("m_mirror", {bus.m_csb, bus.m_web, bus.m_wmask, bus.m_adr, bus.m_din},
                {1'b0, &bus.bweb, ~bus.bweb, bus.badr, bus.bdti});
         if (bus.st_clr) exp_cnt = '0;
         else if (bus.c_vld && !bus.c_rdy && !bus.bcsb && !bus.io_bcf && !waited && exp_cnt != '1) exp_cnt++;
         if (q.size() != 0) begin
            if (bus.c_rrd) begin
               void'(q.pop_front());
               waited = 0;
            end else waited = 1;
         end
         bpend = 0;
         if (!bus.bcsb) begin
            if (&bus.bweb) begin
               bpend = 1;
               bexp = ref_mem[bus.badr];
            end else wr(bus.badr, ~bus.bweb, bus.bdti);
         end else if (bus.c_vld && bus.c_rdy) begin
            if (bus.c_we == 0) q.push_back(ref_mem[bus.c_adr]);
            else wr(bus.c_adr, bus.c_we, bus.c_wdt);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic core(input logic [BW-1:0] we, input logic [AW-1:0] adr, input logic [DW-1:0] d);
      bit got = 0;
      bus.c_vld = 1;
      bus.c_we  = we;
      bus.c_adr = adr;
      bus.c_wdt = d;
      for (int k = 0; k < 50 && !got; k++) begin
         @(negedge clk);
         got = bus.c_rdy;
         if (!got) step();
      end
      chk("grant", got, 1);
      step();
      bus.c_vld = 0;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 2**AW; i++) begin
         macro[i] = '0;
         ref_mem[i] = '0;
      end
      bus.io_bcf = 0; bus.bcsb = 1; bus.bweb = 4'hF; bus.badr = '0; bus.bdti = '0;
      bus.c_vld = 0; bus.c_we = '0; bus.c_adr = '0; bus.c_wdt = '0; bus.c_rrd = 1; bus.st_clr = 0;
      repeat (2) step();
      rst = 0;
      step();
      // partial core write then read back
      core(4'b0011, 11'h005, 32'hDEADBEEF);
      core(4'b0000, 11'h005, '0);
      @(negedge clk);
      chk("t1_rvl", bus.c_rvl, 1);
      chk("t1_rdt", bus.c_rdt, 32'h0000BEEF);
      step();
      // bridge write then read
      bus.bcsb = 0; bus.bweb = 4'h0; bus.badr = 11'h7FF; bus.bdti = 32'h12345678;
      step();
      bus.bweb = 4'hF;
      step();
      bus.bcsb = 1;
      @(negedge clk);
      chk("t2_bdto", bus.bdto, 32'h12345678);
      step();
      // bridge-caused stalls
      bus.bcsb = 0; bus.badr = 11'h001;
      bus.c_vld = 1; bus.c_we = 0; bus.c_adr = 11'h005;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("t3_stall_rdy", bus.c_rdy, 0);
         step();
      end
      bus.bcsb = 1;
      @(negedge clk);
      chk("t3_grant_rdy", bus.c_rdy, 1);
      step();
      bus.c_vld = 0;
      @(negedge clk);
      chk("t3_cnt", bus.st_cnt, 3);
      step();
      bus.st_clr = 1;
      step();
      bus.st_clr = 0;
      @(negedge clk);
      chk("t3_clr", bus.st_cnt, 0);
      step();
      // core read parked while the bridge reads elsewhere
      core(4'hF, 11'h009, 32'hA5A5A5A5);
      bus.c_rrd = 0;
      core(4'h0, 11'h009, '0);
      bus.bcsb = 0; bus.bweb = 4'hF; bus.badr = 11'h7FF;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("t4_rdt", bus.c_rdt, 32'hA5A5A5A5);
         chk("t4_rdy", bus.c_rdy, 0);
         step();
      end
      bus.bcsb = 1; bus.c_rrd = 1;
      @(negedge clk);
      chk("t4_rvl", bus.c_rvl, 1);
      step();
      @(negedge clk);
      chk("t4_done", bus.c_rvl, 0);
      step();
      // boot-config blocks the core and never counts
      bus.io_bcf = 1; bus.c_vld = 1; bus.c_we = 0;
      for (int k = 0; k < 10; k++) begin
         bus.bcsb = k[0];
         @(negedge clk);
         chk("t5_rdy", bus.c_rdy, 0);
         step();
      end
      bus.bcsb = 1;
      @(negedge clk);
      chk("t5_cnt", bus.st_cnt, 0);
      bus.io_bcf = 0; bus.c_vld = 0;
      step();
      // boot-config rising while a response is parked
      bus.c_rrd = 0;
      core(4'h0, 11'h005, '0);
      step();
      bus.io_bcf = 1; bus.c_vld = 1;
      @(negedge clk);
      chk("t5h_rvl", bus.c_rvl, 1);
      chk("t5h_rdt", bus.c_rdt, 32'h0000BEEF);
      bus.c_rrd = 1;
      step();
      @(negedge clk);
      chk("t5h_done", bus.c_rvl, 0);
      chk("t5h_rdy", bus.c_rdy, 0);
      step();
      bus.io_bcf = 0; bus.c_vld = 0;
      step();
      // stall counter saturation
      bus.bcsb = 0; bus.bweb = 4'hF; bus.badr = 11'h002; bus.c_vld = 1; bus.c_we = 0;
      repeat (70000) step();
      @(negedge clk);
      chk("t6_sat", bus.st_cnt, 16'hFFFF);
      step();
      bus.bcsb = 1; bus.c_vld = 0;
      step();
      // reset pulse while HOLD
      core(4'hF, 11'h003, 32'hCAFE0003);
      bus.c_rrd = 0;
      core(4'h0, 11'h003, '0);
      step();
      rst = 1;
      #1;
      chk("t7_rvl_async", bus.c_rvl, 0);
      chk("t7_cnt_async", bus.st_cnt, 0);
      step();
      rst = 0;
      bus.c_rrd = 1;
      step();
      core(4'h0, 11'h003, '0);
      @(negedge clk);
      chk("t7_rdt", bus.c_rdt, 32'hCAFE0003);
      step();
      // randomized traffic against the memory model
      for (int k = 0; k < 2000; k++) begin
         bus.bcsb   = $urandom_range(9) > 2;
         bus.bweb   = $urandom_range(1) ? 4'hF : 4'($urandom);
         bus.badr   = 11'($urandom_range(15));
         bus.bdti   = $urandom;
         bus.c_vld  = $urandom_range(3) != 0;
         bus.c_we   = $urandom_range(1) ? 4'h0 : 4'($urandom);
         bus.c_adr  = 11'($urandom_range(15));
         bus.c_wdt  = $urandom;
         bus.c_rrd  = $urandom_range(9) > 2;
         bus.st_clr = $urandom_range(63) == 0;
         bus.io_bcf = $urandom_range(15) == 0;
         step();
      end
      bus.bcsb = 1; bus.c_vld = 0; bus.c_rrd = 1; bus.io_bcf = 0; bus.st_clr = 0;
      repeat (4) step();
      $display("[TB] %0d tests run, %0d failed", n_tst, n_err);
      $finish;
   end
endmodule

// File: doc/bsram_arb.md
# bsram_arb

Single-port SRAM arbiter placed directly downstream of the SPI boot/debug bridge. It merges the bridge's raw SRAM-style strobes with a valid/ready access port from the core onto one 2048×32 SRAM macro. The bridge has no stall input, so it always wins. Core accesses are granted only in cycles the bridge leaves free and while boot-config is low. Read data returns to the core through a one-entry response buffer with its own handshake.

## Interface
- AW, 11, word address width
- DW, 32, data width
- CW, 16, stall-counter width
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- io_bcf  in  1  boot-config; 1 = bridge owns the macro, core port blocked
- bcsb  in  1  bridge chip select, active-low
- bweb  in  4  bridge byte write enable, active-low; 4'hF with bcsb=0 = read
- badr  in  AW  bridge word address
- bdti  in  DW  bridge write data
- bdto  out  DW  bridge read data (= m_dout)
- c_vld  in  1  core request valid
- c_rdy  out  1  core request accepted when c_vld&c_rdy
- c_we  in  4  core byte write strobes, active-high; 0 = read
- c_adr  in  AW  core word address
- c_wdt  in  DW  core write data
- c_rvl  out  1  core read data valid
- c_rrd  in  1  core read data ready
- c_rdt  out  DW  core read data
- st_clr  in  1  clear stall counter
- st_cnt  out  CW  saturating count of bridge-caused core stalls
- m_csb, m_web  out  1 each  macro select / write enable, active-low
- m_wmask  out  4  macro byte mask, active-high
- m_adr  out  AW; m_din  out  DW; m_dout  in  DW  macro read data, valid the cycle after a read is sampled

## Operation
- bsel = ~bcsb. Bridge path is a combinational pass-through: m_csb=bcsb, m_web=&bweb, m_wmask=~bweb, m_adr=badr, m_din=bdti.
- Core path is used when ~bsel & c_vld & c_rdy: m_csb=0, m_web=~|c_we, m_wmask=c_we, m_adr=c_adr, m_din=c_wdt.
- Otherwise m_csb=1. While rst=1, the core path is gated (c_rdy=0) and the bridge path is unaffected.
- c_rdy = ~rst & ~bsel & ~io_bcf & (state==IDLE | (state==RESP & c_rrd)). The c_rrd→c_rdy path is combinational by design.
- Response FSM:
  - IDLE: accepted core read → RESP; writes produce no response and the FSM stays in IDLE.
  - RESP: c_rvl=1, c_rdt=m_dout. If c_rrd, go to IDLE, or stay in RESP if a new read is accepted this cycle. If ~c_rrd, capture m_dout into hold and go to HOLD.
  - HOLD: c_rvl=1, c_rdt=hold; c_rrd → IDLE.
- Stall counter: increments when c_vld & ~c_rdy & bsel & ~io_bcf & state!=HOLD. Saturates at all-ones. st_clr takes priority over increment; st_clr in the same cycle as an increment yields 0.
- Reset values: state=IDLE, hold=0, st_cnt=0, c_rvl=0, c_rdy=0, c_rdt=m_dout (don't-care).

## Timing
- Core read accepted in cycle N → c_rvl=1 in N+1 with macro data. A bridge access in N+1 does not corrupt it, because m_dout changes only at the N+1 edge and RESP captures before that.
- Back-to-back core reads sustain 1 per cycle while c_rrd=1 and bsel=0.
- Bridge access in cycle N: bdto valid in N+1, zero added latency.
- Simultaneous bridge and core request: the bridge is served, c_rdy=0, the core request holds, and st_cnt increments.
- io_bcf rising mid-HOLD: the pending response still completes and no new requests are accepted.
- rst asserted mid-RESP/HOLD: the response is dropped and c_rvl falls asynchronously.

## Structure
- Package bsram_pkg holds AW/DW/BW constants, the bridge read code 4'hF, and the state enum {IDLE, RESP, HOLD}.
- Sub-module bsram_rsp contains the response FSM and hold register (in: accept_rd, m_dout, c_rrd; out: c_rvl, c_rdt, busy). The top holds the muxing, c_rdy and the stall counter.

## Test plan
- Core write c_we=4'b0011, adr 0x005, data 0xDEADBEEF; then read 0x005 → c_rvl one cycle later with c_rdt=0x0000BEEF (memory pre-zeroed).
- Bridge write bweb=0, adr 0x7FF, data 0x12345678; bridge read next cycle → bdto=0x12345678 in the following cycle; m_* mirrors the bridge exactly.
- Core c_vld held 3 cycles with bcsb=0 → c_rdy=0 for 3 cycles, accepted on the 4th, st_cnt=3; then st_clr → 0.
- Core read with c_rrd=0 for 4 cycles while the bridge reads another address → c_rdt stays at the core's data, c_rdy=0, then completes on c_rrd.
- io_bcf=1 with c_vld=1 for 10 cycles → no core grants and st_cnt unchanged; st_cnt saturates at 0xFFFF under forced 70000 stall cycles.
- rst pulse while in HOLD → c_rvl=0 immediately, state IDLE, st_cnt=0, and the next read behaves normally.
